// File: rtl/can_crc_sequencer.sv
// can_crc_sequencer: parses CAN receive frames, sequences the external CRC-15 unit and checks the received CRC field and delimiter
module can_crc_sequencer #(
  parameter int MAX_DLC = 8
) (
  input  logic        clock,
  input  logic        RESET_N,
  input  logic        BIT_STB,
  input  logic        BITIN,
  input  logic        ABORT,
  input  logic [14:0] CRC_VAL,
  output logic        CRC_CLEAR,
  output logic        CRC_SHIFT,
  output logic        CRC_BITVAL,
  output logic        BUSY,
  output logic        IDE,
  output logic        RTR,
  output logic [3:0]  DLC,
  output logic        CRC_OK,
  output logic        CRC_ERR,
  output logic        FORM_ERR
);
  localparam logic [2:0] IDLE = 3'd0, HEADER = 3'd1, DATA = 3'd2, CRCF = 3'd3, DELIM = 3'd4;
  localparam logic [3:0] MAX4 = 4'(MAX_DLC);
  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [3:0]  cidx_q, cidx_d;
  logic [14:0] rxcrc_q, rxcrc_d;
  logic        ide_q, ide_d, rtr_q, rtr_d;
  logic [3:0]  dlc_q, dlc_d;
  logic        shift_q, shift_d, bitval_q, bitval_d;
  logic        ok_q, ok_d, err_q, err_d, form_q, form_d;
  logic [3:0]  dlc_nx, nb;
  logic        dlc_bit, hdr_end;
  assign dlc_nx  = {dlc_q[2:0], BITIN};
  assign nb      = rtr_q ? 4'd0 : (dlc_nx > MAX4 ? MAX4 : dlc_nx);
  assign dlc_bit = ide_q ? (idx_q inside {[6'd35:6'd38]}) : (idx_q inside {[6'd15:6'd18]});
  assign hdr_end = ide_q ? (idx_q == 6'd38) : (idx_q == 6'd18);
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    cidx_d   = cidx_q;
    rxcrc_d  = rxcrc_q;
    ide_d    = ide_q;
    rtr_d    = rtr_q;
    dlc_d    = dlc_q;
    shift_d  = 1'b0;
    bitval_d = bitval_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    form_d   = 1'b0;
    if (ABORT && state_q != IDLE) begin
      state_d = IDLE;
      idx_d   = 6'd0;
      cnt_d   = 7'd0;
      cidx_d  = 4'd0;
    end else if (BIT_STB) begin
      case (state_q)
        IDLE: if (!BITIN) begin
          state_d  = HEADER;
          idx_d    = 6'd1;
          cidx_d   = 4'd0;
          rxcrc_d  = 15'd0;
          ide_d    = 1'b0;
          rtr_d    = 1'b0;
          dlc_d    = 4'd0;
          shift_d  = 1'b1;
          bitval_d = 1'b0;
        end
        HEADER: begin
          shift_d  = 1'b1;
          bitval_d = BITIN;
          idx_d    = idx_q + 6'd1;
          // bit 12 is RTR for standard frames and SRR for extended ones; index 32 overrides it
          if (idx_q == 6'd12 || (ide_q && idx_q == 6'd32)) rtr_d = BITIN;
          if (idx_q == 6'd13) ide_d = BITIN;
          if (dlc_bit) dlc_d = dlc_nx;
          if (hdr_end) begin
            cnt_d   = {nb, 3'b000};
            state_d = (nb == 4'd0) ? CRCF : DATA;
          end
        end
        DATA: begin
          shift_d  = 1'b1;
          bitval_d = BITIN;
          cnt_d    = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = CRCF;
        end
        CRCF: begin
          rxcrc_d = {rxcrc_q[13:0], BITIN};
          cidx_d  = cidx_q + 4'd1;
          if (cidx_q == 4'd14) begin
            ok_d    = (rxcrc_d == CRC_VAL);
            err_d   = (rxcrc_d != CRC_VAL);
            cidx_d  = 4'd0;
            state_d = DELIM;
          end
        end
        DELIM: begin
          form_d  = !BITIN;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      idx_q    <= 6'd0;
      cnt_q    <= 7'd0;
      cidx_q   <= 4'd0;
      rxcrc_q  <= 15'd0;
      ide_q    <= 1'b0;
      rtr_q    <= 1'b0;
      dlc_q    <= 4'd0;
      shift_q  <= 1'b0;
      bitval_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      form_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      cidx_q   <= cidx_d;
      rxcrc_q  <= rxcrc_d;
      ide_q    <= ide_d;
      rtr_q    <= rtr_d;
      dlc_q    <= dlc_d;
      shift_q  <= shift_d;
      bitval_q <= bitval_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      form_q   <= form_d;
    end
  end
  assign CRC_CLEAR  = (state_q == IDLE);
  assign BUSY       = (state_q != IDLE);
  assign CRC_SHIFT  = shift_q;
  assign CRC_BITVAL = bitval_q;
  assign IDE        = ide_q;
  assign RTR        = rtr_q;
  assign DLC        = dlc_q;
  assign CRC_OK     = ok_q;
  assign CRC_ERR    = err_q;
  assign FORM_ERR   = form_q;
endmodule

// File: tb/tb_can_crc_sequencer.sv
// tb_can_crc_sequencer: table-driven frames against a CAN CRC-15 reference, plus abort and async-reset sequences
module tb_can_crc_sequencer;
  logic        clock = 1'b0;
  logic        RESET_N, BIT_STB, BITIN, ABORT;
  logic [14:0] CRC_VAL;
  logic        CRC_CLEAR, CRC_SHIFT, CRC_BITVAL, BUSY, IDE, RTR;
  logic [3:0]  DLC;
  logic        CRC_OK, CRC_ERR, FORM_ERR;
  can_crc_sequencer #(.MAX_DLC(8)) dut (
    .clock(clock), .RESET_N(RESET_N), .BIT_STB(BIT_STB), .BITIN(BITIN), .ABORT(ABORT),
    .CRC_VAL(CRC_VAL), .CRC_CLEAR(CRC_CLEAR), .CRC_SHIFT(CRC_SHIFT), .CRC_BITVAL(CRC_BITVAL),
    .BUSY(BUSY), .IDE(IDE), .RTR(RTR), .DLC(DLC), .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR),
    .FORM_ERR(FORM_ERR)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic        ide;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    int          nbytes;
    logic        flip;
    logic        delim;
    int          exp_shifts;
    int          exp_ok;
    int          exp_err;
    int          exp_form;
  } vec_t;
  vec_t        tbl[8];
  int          nvec = 0, nfail = 0;
  int          nshift, nok, nerr, nform;
  logic [14:0] mcrc;
  logic        fbits[$];
  function automatic logic [14:0] crc_step(logic [14:0] c, logic b);
    crc_step = {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction
  // external CRC-15 unit plus pulse counters
  always @(posedge clock or negedge RESET_N) begin
    if (!RESET_N) begin
      mcrc <= 15'd0; nshift <= 0; nok <= 0; nerr <= 0; nform <= 0;
    end else begin
      mcrc   <= CRC_CLEAR ? 15'd0 : (CRC_SHIFT ? crc_step(mcrc, CRC_BITVAL) : mcrc);
      nshift <= nshift + int'(CRC_SHIFT);
      nok    <= nok + int'(CRC_OK);
      nerr   <= nerr + int'(CRC_ERR);
      nform  <= nform + int'(FORM_ERR);
    end
  end
  assign CRC_VAL = mcrc;
  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic send_bit(input logic b, input logic ab);
    @(negedge clock);
    BITIN = b; BIT_STB = 1'b1; ABORT = ab;
    @(negedge clock);
    BIT_STB = 1'b0; ABORT = 1'b0;
  endtask
  task automatic build_frame(input vec_t v);
    fbits.delete();
    fbits.push_back(1'b0);
    if (!v.ide) begin
      for (int i = 10; i >= 0; i--) fbits.push_back(v.id[i]);
      fbits.push_back(v.rtr); fbits.push_back(1'b0); fbits.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) fbits.push_back(v.id[i]);
      fbits.push_back(1'b1); fbits.push_back(1'b1);
      for (int i = 17; i >= 0; i--) fbits.push_back(v.id[i]);
      fbits.push_back(v.rtr); fbits.push_back(1'b0); fbits.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) fbits.push_back(v.dlc[i]);
    for (int i = 0; i < v.nbytes * 8; i++) fbits.push_back(1'($urandom_range(0, 1)));
  endtask
  task automatic run_frame(input int k, input vec_t v);
    logic [14:0] ref_crc, fld;
    int s0, o0, e0, f0;
    build_frame(v);
    ref_crc = 15'd0;
    foreach (fbits[i]) ref_crc = crc_step(ref_crc, fbits[i]);
    fld = v.flip ? (ref_crc ^ 15'h0001) : ref_crc;
    s0 = nshift; o0 = nok; e0 = nerr; f0 = nform;
    foreach (fbits[i]) send_bit(fbits[i], 1'b0);
    for (int i = 14; i >= 0; i--) send_bit(fld[i], 1'b0);
    chk($sformatf("v%0d crc_ok", k), int'(CRC_OK), v.exp_ok);
    chk($sformatf("v%0d crc_err", k), int'(CRC_ERR), v.exp_err);
    chk($sformatf("v%0d unit_crc", k), int'(mcrc), int'(ref_crc));
    send_bit(v.delim, 1'b0);
    chk($sformatf("v%0d form_err", k), int'(FORM_ERR), v.exp_form);
    chk($sformatf("v%0d busy_after", k), int'(BUSY), 0);
    repeat (3) @(negedge clock);
    chk($sformatf("v%0d shifts", k), nshift - s0, v.exp_shifts);
    chk($sformatf("v%0d ok_pulses", k), nok - o0, v.exp_ok);
    chk($sformatf("v%0d err_pulses", k), nerr - e0, v.exp_err);
    chk($sformatf("v%0d form_pulses", k), nform - f0, v.exp_form);
    chk($sformatf("v%0d ide", k), int'(IDE), int'(v.ide));
    chk($sformatf("v%0d rtr", k), int'(RTR), int'(v.rtr));
    chk($sformatf("v%0d dlc", k), int'(DLC), int'(v.dlc));
  endtask
  initial begin
    int s0, o0, e0, f0;
    tbl[0] = '{1'b0, 1'b0, 29'h0,        4'd0,  0, 1'b0, 1'b1, 19, 1, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 29'h123,      4'd8,  8, 1'b0, 1'b1, 83, 1, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 29'h123,      4'd8,  8, 1'b1, 1'b1, 83, 0, 1, 0};
    tbl[3] = '{1'b1, 1'b1, 29'h0ABCDEF3, 4'd5,  0, 1'b0, 1'b1, 39, 1, 0, 0};
    tbl[4] = '{1'b0, 1'b0, 29'h7F0,      4'd15, 8, 1'b0, 1'b1, 83, 1, 0, 0};
    tbl[5] = '{1'b0, 1'b0, 29'h055,      4'd2,  2, 1'b0, 1'b0, 35, 1, 0, 1};
    tbl[6] = '{1'b1, 1'b0, 29'h1234567,  4'd3,  3, 1'b0, 1'b1, 63, 1, 0, 0};
    tbl[7] = '{1'b0, 1'b1, 29'h3FF,      4'd4,  0, 1'b0, 1'b1, 19, 1, 0, 0};
    RESET_N = 1'b0; BIT_STB = 1'b0; BITIN = 1'b1; ABORT = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst clear", int'(CRC_CLEAR), 1);
    chk("rst busy", int'(BUSY), 0);
    chk("rst shift", int'(CRC_SHIFT), 0);
    chk("rst dlc", int'(DLC), 0);
    RESET_N = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("idle recessive busy", int'(BUSY), 0);
    for (int k = 0; k < 8; k++) run_frame(k, tbl[k]);
    // abort on the 10th data bit of an 8-byte standard frame
    build_frame(tbl[1]);
    s0 = nshift; o0 = nok; e0 = nerr; f0 = nform;
    for (int i = 0; i < 28; i++) send_bit(fbits[i], 1'b0);
    chk("pre-abort busy", int'(BUSY), 1);
    send_bit(fbits[28], 1'b1);
    chk("abort shift", int'(CRC_SHIFT), 0);
    chk("abort busy", int'(BUSY), 0);
    chk("abort clear", int'(CRC_CLEAR), 1);
    chk("abort dlc held", int'(DLC), 8);
    repeat (3) @(negedge clock);
    chk("abort shifts", nshift - s0, 28);
    chk("abort pulses", (nok - o0) + (nerr - e0) + (nform - f0), 0);
    run_frame(8, tbl[1]);
    // async reset partway through an extended header
    build_frame(tbl[3]);
    for (int i = 0; i < 14; i++) send_bit(fbits[i], 1'b0);
    chk("mid ide", int'(IDE), 1);
    chk("mid rtr", int'(RTR), 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("async busy", int'(BUSY), 0);
    chk("async clear", int'(CRC_CLEAR), 1);
    chk("async ide", int'(IDE), 0);
    chk("async rtr", int'(RTR), 0);
    chk("async shift", int'(CRC_SHIFT), 0);
    #3 RESET_N = 1'b1;
    run_frame(9, tbl[0]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/can_crc_sequencer.md
Name: can_crc_sequencer

Overview:
Frame-level controller for the CAN receive CRC-15 unit. It takes destuffed receive bits, parses the CAN arbitration and control fields to find the frame length, and drives the CRC unit's clear, shift and bit inputs over SOF through the last data bit. It captures the received 15-bit CRC field, compares it against the CRC unit's value, and checks the CRC delimiter. It sits between the bit-destuffer and the frame decoder, in the decoder path.

Parameters:
MAX_DLC, 8, data-byte clamp; a received DLC above this counts as MAX_DLC bytes.

Ports:
clock  input  1  system clock; all logic on the rising edge.
RESET_N  input  1  asynchronous active-low reset.
BIT_STB  input  1  one-cycle strobe: BITIN holds a valid destuffed bit. Strobes are at least 2 cycles apart.
BITIN  input  1  destuffed receive bit (0 = dominant).
ABORT  input  1  stuff or bit error from upstream; drop the frame.
CRC_VAL  input  15  current value of the external CRC-15 unit.
CRC_CLEAR  output  1  clear to the CRC unit; high while IDLE.
CRC_SHIFT  output  1  one-cycle enable: the CRC unit shifts CRC_BITVAL on this edge.
CRC_BITVAL  output  1  bit presented to the CRC unit.
BUSY  output  1  high in any state other than IDLE.
IDE  output  1  captured IDE bit; valid from the end of the header until the next SOF.
RTR  output  1  captured RTR bit; same validity as IDE.
DLC  output  4  captured raw DLC; same validity as IDE.
CRC_OK  output  1  one-cycle pulse: received CRC equals CRC_VAL.
CRC_ERR  output  1  one-cycle pulse: CRC mismatch.
FORM_ERR  output  1  one-cycle pulse: CRC delimiter was dominant.

Behaviour:
- Reset (async, RESET_N=0): state IDLE, all counters 0, CRC_CLEAR=1, every other output 0.
- All outputs are registered. Each response appears one cycle after the BIT_STB that causes it.
- States: IDLE, HEADER, DATA, CRCF, DELIM.
- IDLE:
  - BIT_STB with BITIN=0 is SOF: go to HEADER, set bit index to 1, and issue CRC_SHIFT with CRC_BITVAL=0.
  - CRC_CLEAR falls on the same edge that CRC_SHIFT rises.
  - BIT_STB with BITIN=1 is ignored.
- CRC_SHIFT/CRC_BITVAL: one pulse, carrying BITIN, for every strobe in HEADER and DATA, including SOF. No pulses in CRCF or DELIM.
- HEADER, bit index counted from SOF=0:
  - Index 12 is captured as RTR, then overwritten if the frame turns out to be extended.
  - Index 13 is IDE.
  - IDE=0 (standard): DLC is indices 15..18; header ends at index 18, length 19.
  - IDE=1 (extended): RTR is index 32 and DLC is indices 35..38; header ends at index 38, length 39.
- End of header:
  - Data byte count N = 0 if RTR=1, otherwise min(DLC, MAX_DLC).
  - N=0: go directly to CRCF. Otherwise go to DATA with a bit counter of 8*N.
- DATA: decrement the counter on each strobe; at 0, go to CRCF.
- CRCF:
  - Shift 15 bits, MSB first, into a receive-CRC register.
  - On the 15th strobe, compare against CRC_VAL. Pulse CRC_OK on equal, CRC_ERR otherwise. Go to DELIM.
  - CRC_VAL is stable by then, because the last CRC_SHIFT was at least one bit time earlier.
- DELIM: next strobe with BITIN=0 pulses FORM_ERR. Go to IDLE on either bit value.
- ABORT:
  - Any state with ABORT=1 goes to IDLE on the next edge with no result pulses.
  - ABORT wins over a simultaneous BIT_STB; no CRC_SHIFT is issued.
  - ABORT in IDLE has no effect.
- IDE, RTR and DLC hold their values after the frame and through an abort, until the next SOF clears them to 0.
- Deasserting RESET_N mid-frame returns to IDLE immediately; no partial pulses.
- Counter widths: 6-bit header index, 7-bit data counter (maximum 64), 4-bit CRC index.

Test Plan:
1. Standard frame, ID=0x000, RTR=0, DLC=0, all 19 header bits 0, CRC field all 0, delimiter 1 -> exactly 19 CRC_SHIFT pulses, all CRC_BITVAL=0. Bench CRC model stays 0x0000. One CRC_OK pulse, no CRC_ERR, no FORM_ERR. IDE=0, RTR=0, DLC=0. BUSY returns to 0 after the delimiter.
2. Standard frame, DLC=8, random data, CRC field from a reference CRC model -> 83 CRC_SHIFT pulses and CRC_OK. Flip one CRC bit -> CRC_ERR, no CRC_OK.
3. Extended frame, RTR=1, DLC=5 -> 39 CRC_SHIFT pulses and no data phase. IDE=1, RTR=1, DLC=5. CRC checked after 15 further strobes.
4. Standard frame, DLC=15 -> treated as 8 bytes: 83 shifts, CRC_OK when the CRC is correct; DLC output reads 15.
5. Correct CRC, delimiter 0 -> CRC_OK, then FORM_ERR one cycle after the delimiter strobe; state returns to IDLE.
6. ABORT coincident with the 10th data-bit strobe -> no CRC_SHIFT for that bit, IDLE next cycle, CRC_CLEAR=1, no result pulses. A following valid frame passes. RESET_N pulsed low mid-header -> all outputs return to their reset values asynchronously.
